// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream to instruction-memory word loader
//
// Purpose: packs a big-endian byte stream into 32-bit words and writes each
// word to instruction memory at consecutive word addresses, starting at
// BASE_ADDR. Optional readback compare of every written word.
//
// Optional feature macro: IMEM_LOADER_VERIFY_EN (adds READBACK state and
// the sticky verify_err flag; otherwise im_rd and verify_err are tied 0).
//
// Ports:
//   clk, reset_n           clock, asynchronous active-low reset
//   start, word_count      load request and number of words (1..1024)
//   byte_in, byte_valid    program byte stream, MSB of each word first
//   byte_ready             loader accepts a byte this cycle
//   im_addr, im_d_in       memory byte address and write data
//   im_cs, im_wr, im_rd    memory strobes
//   im_d_out               memory asynchronous read data
//   busy, done, verify_err status

module imem_loader #(
  parameter logic [11:0] BASE_ADDR = 12'h000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [10:0] word_count,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic [11:0] im_addr,
  output logic [31:0] im_d_in,
  output logic        im_cs,
  output logic        im_wr,
  output logic        im_rd,
  input  logic [31:0] im_d_out,
  output logic        busy,
  output logic        done,
  output logic        verify_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_WRITE,
`ifdef IMEM_LOADER_VERIFY_EN
    S_READBACK,
`endif
    S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [11:0] r_addr;
  logic [31:0] r_data;
  logic [1:0]  r_byte_idx;
  logic [10:0] r_count;
  logic [10:0] r_words;

  logic w_start_ok;
  logic w_xfer;
  logic w_last_word;
  logic w_word_end;

  assign w_start_ok  = start && (word_count != 11'd0) &&
                       ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_xfer      = byte_valid && (r_state == S_COLLECT);
  assign w_last_word = ((r_words + 11'd1) == r_count);

  // The final step of a word is WRITE, or READBACK when verification is on.
`ifdef IMEM_LOADER_VERIFY_EN
  assign w_word_end = (r_state == S_READBACK);
`else
  assign w_word_end = (r_state == S_WRITE);
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    byte_ready   = 1'b0;
    im_cs        = 1'b0;
    im_wr        = 1'b0;
    im_rd        = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start_ok) w_next_state = S_COLLECT;
      end
      S_COLLECT: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (w_xfer && (r_byte_idx == 2'd3)) w_next_state = S_WRITE;
      end
      S_WRITE: begin
        im_cs = 1'b1;
        im_wr = 1'b1;
        busy  = 1'b1;
`ifdef IMEM_LOADER_VERIFY_EN
        w_next_state = S_READBACK;
`else
        w_next_state = w_last_word ? S_DONE : S_COLLECT;
`endif
      end
`ifdef IMEM_LOADER_VERIFY_EN
      S_READBACK: begin
        im_cs = 1'b1;
        im_rd = 1'b1;
        busy  = 1'b1;
        w_next_state = w_last_word ? S_DONE : S_COLLECT;
      end
`endif
      S_DONE: begin
        done = 1'b1;
        if (w_start_ok) w_next_state = S_COLLECT;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr     <= 12'h000;
      r_data     <= 32'h0;
      r_byte_idx <= 2'd0;
      r_count    <= 11'd0;
      r_words    <= 11'd0;
    end else begin
      if (w_start_ok) begin
        r_count    <= word_count;
        r_addr     <= BASE_ADDR;
        r_byte_idx <= 2'd0;
        r_words    <= 11'd0;
      end
      if (w_xfer) begin
        // Byte k lands at bit offset 8*(3-k); ~k equals 3-k for 2-bit k.
        r_data[{~r_byte_idx, 3'b000} +: 8] <= byte_in;
        r_byte_idx <= r_byte_idx + 2'd1;
      end
      if (w_word_end) begin
        r_words <= r_words + 11'd1;
        // 12-bit add wraps 12'hFFC to 12'h000.
        if (!w_last_word) r_addr <= r_addr + 12'd4;
      end
    end
  end

`ifdef IMEM_LOADER_VERIFY_EN
  logic r_verify_err;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_verify_err <= 1'b0;
    end else if (w_start_ok) begin
      r_verify_err <= 1'b0;
    end else if ((r_state == S_READBACK) && (im_d_out != r_data)) begin
      r_verify_err <= 1'b1;
    end
  end

  assign verify_err = r_verify_err;
`else
  logic w_unused_rd;
  assign w_unused_rd = ^im_d_out;
  assign verify_err  = 1'b0;
`endif

  assign im_addr = r_addr;
  assign im_d_in = r_data;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed self-checking bench for imem_loader

module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [10:0] word_count;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready, im_cs, im_wr, im_rd, busy, done, verify_err;
  logic [11:0] im_addr;
  logic [31:0] im_d_in, im_d_out;
  logic        h_byte_ready, h_im_cs, h_im_wr, h_im_rd, h_busy, h_done, h_verify_err;
  logic [11:0] h_im_addr;
  logic [31:0] h_im_d_in;
  logic [31:0] h_im_d_out = 32'h0;

  int checks = 0;
  int errors = 0;

  logic [11:0] wq_addr[$];
  logic [31:0] wq_data[$];
  logic [11:0] hq_addr[$];
  int ready_in_write = 0;
  int rd_wr_both = 0;
  int rd_seen = 0;
  bit corrupt = 1'b0;
  logic [31:0] mem [0:1023];

  always #5 clk = ~clk;

  imem_loader #(.BASE_ADDR(12'h000)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .word_count(word_count),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .im_addr(im_addr), .im_d_in(im_d_in), .im_cs(im_cs), .im_wr(im_wr),
    .im_rd(im_rd), .im_d_out(im_d_out), .busy(busy), .done(done),
    .verify_err(verify_err)
  );

  imem_loader #(.BASE_ADDR(12'hFF8)) dut_hi (
    .clk(clk), .reset_n(reset_n), .start(start), .word_count(word_count),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(h_byte_ready),
    .im_addr(h_im_addr), .im_d_in(h_im_d_in), .im_cs(h_im_cs), .im_wr(h_im_wr),
    .im_rd(h_im_rd), .im_d_out(h_im_d_out), .busy(h_busy), .done(h_done),
    .verify_err(h_verify_err)
  );

  // Memory model: synchronous write, asynchronous read; word at 12'h004 can be corrupted.
  always @(posedge clk) if (im_cs && im_wr) mem[im_addr[11:2]] <= im_d_in;
  assign im_d_out = (corrupt && im_addr == 12'h004) ? 32'hDEADBEEF : mem[im_addr[11:2]];

  always @(negedge clk) begin
    if (im_cs && im_wr) begin
      wq_addr.push_back(im_addr);
      wq_data.push_back(im_d_in);
      if (byte_ready) ready_in_write++;
    end
    if (h_im_cs && h_im_wr) hq_addr.push_back(h_im_addr);
    if (im_rd && im_wr) rd_wr_both++;
    if (im_rd) rd_seen++;
  end

  task automatic clear_q();
    wq_addr.delete(); wq_data.delete(); hq_addr.delete();
  endtask

  task automatic do_start(input logic [10:0] n);
    @(negedge clk); start = 1'b1; word_count = n;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int t;
    if (gap) begin byte_valid = 1'b0; @(negedge clk); end
    byte_in = b; byte_valid = 1'b1; t = 0;
    while (byte_ready !== 1'b1 && t < 40) begin @(negedge clk); t++; end
    if (t >= 40) begin checks++; errors++; $display("FAIL byte_timeout got no byte_ready exp byte_ready=1"); end
    @(negedge clk); byte_valid = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    int t = 0;
    while (done !== 1'b1 && t < 200) begin @(negedge clk); t++; end
    ok = (done === 1'b1);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; word_count = 11'd0; byte_in = 8'h0; byte_valid = 1'b0;
    #3;
    checks++; if (byte_ready !== 1'b0) begin errors++; $display("FAIL reset_byte_ready got %b exp 0", byte_ready); end
    checks++; if (im_addr !== 12'h000) begin errors++; $display("FAIL reset_im_addr got %h exp 000", im_addr); end
    checks++; if (im_d_in !== 32'h0) begin errors++; $display("FAIL reset_im_d_in got %h exp 0", im_d_in); end
    checks++; if ({im_cs, im_wr, im_rd} !== 3'b000) begin errors++; $display("FAIL reset_strobes got %b exp 000", {im_cs, im_wr, im_rd}); end
    checks++; if ({busy, done, verify_err} !== 3'b000) begin errors++; $display("FAIL reset_status got %b exp 000", {busy, done, verify_err}); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checks++; if ({busy, done, byte_ready} !== 3'b000) begin errors++; $display("FAIL idle_status got %b exp 000", {busy, done, byte_ready}); end
  endtask

  task automatic test_single();
    bit ok;
    clear_q();
    do_start(11'd1);
    checks++; if ({busy, byte_ready} !== 2'b11) begin errors++; $display("FAIL single_collect got %b exp 11", {busy, byte_ready}); end
    send_byte(8'h8C, 0); send_byte(8'h01, 0); send_byte(8'h00, 0); send_byte(8'h04, 0);
    checks++; if ({im_cs, im_wr, im_rd, byte_ready} !== 4'b1100) begin errors++; $display("FAIL single_write_cycle got %b exp 1100", {im_cs, im_wr, im_rd, byte_ready}); end
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_done_timeout got done=%b exp 1", done); end
    checks++; if (wq_addr.size() !== 1) begin errors++; $display("FAIL single_write_count got %0d exp 1", wq_addr.size()); end
    else begin
      checks++; if (wq_addr[0] !== 12'h000) begin errors++; $display("FAIL single_addr got %h exp 000", wq_addr[0]); end
      checks++; if (wq_data[0] !== 32'h8C010004) begin errors++; $display("FAIL single_data got %h exp 8C010004", wq_data[0]); end
    end
    checks++; if ({done, busy, im_cs} !== 3'b100) begin errors++; $display("FAIL single_final got %b exp 100", {done, busy, im_cs}); end
  endtask

  task automatic test_gaps();
    bit ok;
    logic [7:0]  bytes [0:11] = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB,
                                   8'hCD, 8'hEF, 8'hF0, 8'h0F, 8'h5A, 8'hA5};
    logic [31:0] exp_d [0:2]  = '{32'h01234567, 32'h89ABCDEF, 32'hF00F5AA5};
    logic [11:0] exp_a [0:2]  = '{12'h000, 12'h004, 12'h008};
    logic [11:0] exp_h [0:2]  = '{12'hFF8, 12'hFFC, 12'h000};
    clear_q();
    ready_in_write = 0;
    do_start(11'd3);
    for (int i = 0; i < 12; i++) send_byte(bytes[i], 1);
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL gaps_done_timeout got done=%b exp 1", done); end
    checks++; if (wq_addr.size() !== 3) begin errors++; $display("FAIL gaps_write_count got %0d exp 3", wq_addr.size()); end
    else for (int i = 0; i < 3; i++) begin
      checks++; if (wq_addr[i] !== exp_a[i]) begin errors++; $display("FAIL gaps_addr%0d got %h exp %h", i, wq_addr[i], exp_a[i]); end
      checks++; if (wq_data[i] !== exp_d[i]) begin errors++; $display("FAIL gaps_data%0d got %h exp %h", i, wq_data[i], exp_d[i]); end
    end
    checks++; if (ready_in_write !== 0) begin errors++; $display("FAIL gaps_ready_in_write got %0d exp 0", ready_in_write); end
    checks++; if (hq_addr.size() !== 3) begin errors++; $display("FAIL wrap_write_count got %0d exp 3", hq_addr.size()); end
    else for (int i = 0; i < 3; i++) begin
      checks++; if (hq_addr[i] !== exp_h[i]) begin errors++; $display("FAIL wrap_addr%0d got %h exp %h", i, hq_addr[i], exp_h[i]); end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_start(11'd2);
    send_byte(8'hAA, 0); send_byte(8'hBB, 0);
    reset_n = 1'b0;
    #1;
    checks++; if ({busy, byte_ready, done, im_cs} !== 4'b0000) begin errors++; $display("FAIL midreset_status got %b exp 0000", {busy, byte_ready, done, im_cs}); end
    checks++; if (im_d_in !== 32'h0 || im_addr !== 12'h000) begin errors++; $display("FAIL midreset_data got %h/%h exp 0/000", im_d_in, im_addr); end
    @(negedge clk); reset_n = 1'b1;
    clear_q();
    do_start(11'd1);
    send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h44, 0);
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL midreset_done_timeout got done=%b exp 1", done); end
    checks++; if (wq_addr.size() !== 1) begin errors++; $display("FAIL midreset_write_count got %0d exp 1", wq_addr.size()); end
    else begin
      checks++; if (wq_data[0] !== 32'h11223344 || wq_addr[0] !== 12'h000) begin errors++; $display("FAIL midreset_write got %h@%h exp 11223344@000", wq_data[0], wq_addr[0]); end
    end
  endtask

  task automatic test_ignored_start();
    bit ok;
    do_start(11'd0);
    checks++; if ({done, busy} !== 2'b10) begin errors++; $display("FAIL zero_start got %b exp 10", {done, busy}); end
    clear_q();
    do_start(11'd1);
    send_byte(8'hCA, 0); send_byte(8'hFE, 0);
    do_start(11'd5);
    send_byte(8'hBA, 0); send_byte(8'hBE, 0);
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL busy_start_done_timeout got done=%b exp 1", done); end
    checks++; if (wq_data.size() !== 1) begin errors++; $display("FAIL busy_start_writes got %0d exp 1", wq_data.size()); end
    else begin
      checks++; if (wq_data[0] !== 32'hCAFEBABE) begin errors++; $display("FAIL busy_start_data got %h exp CAFEBABE", wq_data[0]); end
    end
  endtask

`ifdef IMEM_LOADER_VERIFY_EN
  task automatic test_verify();
    bit ok;
    corrupt = 1'b1;
    do_start(11'd3);
    send_byte(8'h10, 0); send_byte(8'h20, 0); send_byte(8'h30, 0); send_byte(8'h40, 0);
    @(negedge clk);
    checks++; if ({im_cs, im_rd, im_wr, im_addr} !== {3'b110, 12'h000}) begin errors++; $display("FAIL verify_readback got %b/%h exp 110/000", {im_cs, im_rd, im_wr}, im_addr); end
    @(negedge clk);
    checks++; if (verify_err !== 1'b0) begin errors++; $display("FAIL verify_word0 got %b exp 0", verify_err); end
    send_byte(8'h50, 0); send_byte(8'h60, 0); send_byte(8'h70, 0); send_byte(8'h80, 0);
    repeat (2) @(negedge clk);
    checks++; if (verify_err !== 1'b1) begin errors++; $display("FAIL verify_word1 got %b exp 1", verify_err); end
    send_byte(8'h90, 0); send_byte(8'hA0, 0); send_byte(8'hB0, 0); send_byte(8'hC0, 0);
    wait_done(ok);
    checks++; if ({ok, verify_err} !== 2'b11) begin errors++; $display("FAIL verify_done got %b exp 11", {ok, verify_err}); end
    corrupt = 1'b0;
    do_start(11'd1);
    checks++; if (verify_err !== 1'b0) begin errors++; $display("FAIL verify_clear got %b exp 0", verify_err); end
    send_byte(8'h01, 0); send_byte(8'h02, 0); send_byte(8'h03, 0); send_byte(8'h04, 0);
    wait_done(ok);
    checks++; if ({ok, verify_err} !== 2'b10) begin errors++; $display("FAIL verify_clean got %b exp 10", {ok, verify_err}); end
  endtask
`else
  task automatic test_no_verify();
    checks++; if (rd_seen !== 0) begin errors++; $display("FAIL no_verify_rd got %0d exp 0", rd_seen); end
    checks++; if (verify_err !== 1'b0) begin errors++; $display("FAIL no_verify_err got %b exp 0", verify_err); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_gaps();
    test_reset_mid();
    test_ignored_start();
`ifdef IMEM_LOADER_VERIFY_EN
    test_verify();
`else
    test_no_verify();
`endif
    checks++; if (rd_wr_both !== 0) begin errors++; $display("FAIL rd_wr_overlap got %0d exp 0", rd_wr_both); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter BASE_ADDR, default 12'h000, byte address of the first loaded word; SHALL be a multiple of 4.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 reset_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  begin load; sampled only in IDLE or DONE.
REQ-005 word_count  input  11  words to load, 1..1024; latched on accepted start.
REQ-006 byte_in  input  8  program byte stream, most significant byte of each word first.
REQ-007 byte_valid  input  1  byte_in valid.
REQ-008 byte_ready  output  1  loader accepts byte this cycle.
REQ-009 im_addr  output  12  instruction memory byte address.
REQ-010 im_d_in  output  32  write data to instruction memory.
REQ-011 im_cs, im_wr, im_rd  output  1 each  memory chip select, write, read strobes.
REQ-012 im_d_out  input  32  instruction memory asynchronous read data.
REQ-013 busy  output  1  load in progress.
REQ-014 done  output  1  load complete; held until next accepted start.
REQ-015 verify_err  output  1  sticky readback mismatch flag.

Function
REQ-016 FSM states SHALL be IDLE, COLLECT, WRITE, READBACK, DONE; READBACK exists only per REQ-030.
REQ-017 IDLE/DONE: start=1 with word_count!=0 SHALL latch word_count, set im_addr=BASE_ADDR, clear byte index, done and verify_err, enter COLLECT next cycle.
REQ-018 start with word_count=0 SHALL be ignored; start in COLLECT/WRITE/READBACK SHALL be ignored.
REQ-019 byte_ready SHALL be 1 only in COLLECT; a byte transfers on the cycle byte_valid&byte_ready=1.
REQ-020 Byte k (k=0..3) of a word SHALL be placed in im_d_in bits [31-8k:24-8k]; byte 0 at [31:24].
REQ-021 After the 4th transfer of a word the FSM SHALL enter WRITE; no further byte accepted that cycle onward until COLLECT re-entered.
REQ-022 WRITE SHALL last exactly one cycle with im_cs=1, im_wr=1, im_rd=0, im_addr and im_d_in stable.
REQ-023 After the last write step of a word: if words written == latched count, enter DONE; else im_addr += 4 (modulo 4096, 12'hFFC wraps to 12'h000) and enter COLLECT.
REQ-024 Minimum latency per word: 4 byte cycles + 1 write cycle (+1 READBACK when enabled).
REQ-025 busy SHALL be 1 in COLLECT, WRITE, READBACK; 0 in IDLE and DONE.
REQ-026 Outside WRITE/READBACK im_cs, im_wr, im_rd SHALL be 0; im_wr and im_rd never simultaneously 1.
REQ-027 byte_valid gaps SHALL stall COLLECT indefinitely without losing partial-word bytes.

Reset
REQ-028 reset_n=0 SHALL immediately force IDLE, byte_ready=0, im_cs=im_wr=im_rd=0, im_addr=12'h000, im_d_in=32'h0, busy=0, done=0, verify_err=0, byte index and word counter 0.
REQ-029 Reset during any state SHALL discard the partial word and the load; a fresh start is required.

Configuration
REQ-030 Macro IMEM_LOADER_VERIFY_EN defined: after each WRITE the FSM SHALL spend one READBACK cycle with im_cs=1, im_rd=1, im_wr=0, same im_addr, compare im_d_out to im_d_in, and set verify_err=1 on mismatch (sticky until next accepted start); load continues regardless.
REQ-031 Macro undefined: no READBACK state, im_rd SHALL be tied 0, verify_err SHALL be tied 0, WRITE proceeds directly per REQ-023.

Verification
REQ-032 BASE_ADDR=0, word_count=1, bytes 8C,01,00,04 back-to-back -> one WRITE cycle at im_addr=12'h000, im_d_in=32'h8C010004, then done=1, busy=0.
REQ-033 word_count=3, byte_valid toggled every other cycle -> writes at 12'h000, 12'h004, 12'h008 with correct words; byte_ready=0 during each WRITE.
REQ-034 BASE_ADDR=12'hFF8, word_count=3 -> write addresses 12'hFF8, 12'hFFC, 12'h000.
REQ-035 reset_n pulsed low after 2 bytes of word 1, then start with word_count=1 and bytes 11,22,33,44 -> single write of 32'h11223344 at BASE_ADDR; outputs 0 during reset.
REQ-036 IMEM_LOADER_VERIFY_EN defined, memory model forcing im_d_out=32'hDEADBEEF on second word -> verify_err=1 after that READBACK, stays 1 through DONE, clears on next start; start during busy and start with word_count=0 produce no change.
